// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine cycle controller.
// Holds the phase encoding, the preset field width, the default timing
// parameters and the helpers that pick the next phase and its duration.
package wm_pkg;

    localparam int PRESET_W            = 5;
    localparam int TICK_DIV_DEFAULT    = 4;
    localparam int DRAIN_UNITS_DEFAULT = 3;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_RINSE = 3'd3,
        PH_SPIN  = 3'd4,
        PH_DONE  = 3'd5,
        PH_ABORT = 3'd6
    } phase_e;

    typedef struct packed {
        logic [PRESET_W-1:0] cloth;
        logic [PRESET_W-1:0] wash;
        logic [PRESET_W-1:0] rinse;
        logic [PRESET_W-1:0] spin;
    } preset_t;

    // First later run phase with a nonzero duration; DONE when none is left.
    function automatic phase_e next_run_phase(input phase_e cur, input preset_t p);
        phase_e nxt;
        if ((cur < PH_FILL) && (p.cloth != 5'd0)) begin
            nxt = PH_FILL;
        end else if ((cur < PH_WASH) && (p.wash != 5'd0)) begin
            nxt = PH_WASH;
        end else if ((cur < PH_RINSE) && (p.rinse != 5'd0)) begin
            nxt = PH_RINSE;
        end else if ((cur < PH_SPIN) && (p.spin != 5'd0)) begin
            nxt = PH_SPIN;
        end else begin
            nxt = PH_DONE;
        end
        return nxt;
    endfunction

    // Duration in time units of a run phase.
    function automatic logic [PRESET_W-1:0] phase_duration(input phase_e ph, input preset_t p);
        logic [PRESET_W-1:0] dur;
        case (ph)
            PH_FILL:  dur = p.cloth;
            PH_WASH:  dur = p.wash;
            PH_RINSE: dur = p.rinse;
            PH_SPIN:  dur = p.spin;
            default:  dur = 5'd0;
        endcase
        return dur;
    endfunction

endpackage

// File: rtl/wm_tick_gen.sv
// Time-unit prescaler for the cycle controller.
// Ports: clk, rst (sync, active high), clear (restart the unit at count 0),
// hold (freeze the count), tick (high on the last clock of a unit when not held).
module wm_tick_gen
    import wm_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_r;

    // Prescaler count: clear beats hold so a newly entered phase always starts a full unit.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (hold) begin
            count_r <= count_r;
        end else if (count_r == LAST_COUNT) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign tick = (count_r == LAST_COUNT) && !hold;

endmodule

// File: rtl/wm_cycle_controller.sv
// Washing cycle sequencer: latches the preset on an accepted start, then runs
// FILL -> WASH -> RINSE -> SPIN -> DONE, skipping zero-length phases, with
// pause/door freeze and an abort drain.
// Inputs : clk, rst (sync, active high), start, pause, door_open, abort,
//          cloth_out/wash_out/rinse_out/spin_out (5-bit preset fields).
// Outputs: phase (3-bit code), remaining (units left), valve, motor, drain,
//          spin_hi, busy, done -- all registered.
module wm_cycle_controller
    import wm_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_DEFAULT,
    parameter int DRAIN_UNITS = DRAIN_UNITS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       door_open,
    input  logic       abort,
    input  logic [4:0] wash_out,
    input  logic [4:0] rinse_out,
    input  logic [4:0] spin_out,
    input  logic [4:0] cloth_out,
    output logic [2:0] phase,
    output logic [4:0] remaining,
    output logic       valve,
    output logic       motor,
    output logic       drain,
    output logic       spin_hi,
    output logic       busy,
    output logic       done
);

    localparam logic [4:0] DRAIN_LOAD = 5'(DRAIN_UNITS);

    phase_e     state_r, next_state_s;
    logic [4:0] remaining_r, rem_step_s, rem_entry_s, rem_next_s;
    preset_t    preset_r, in_preset_s, src_preset_s;
    logic       latch_s, entering_s, run_s, frozen_s, hold_s, tick_s;
    logic       next_run_s, next_frozen_s;
    logic       valve_r, motor_r, drain_r, spin_hi_r, busy_r, done_r;
    logic       valve_s, motor_s, drain_s, spin_hi_s;

    assign in_preset_s  = '{cloth: cloth_out, wash: wash_out, rinse: rinse_out, spin: spin_out};
    // On the start cycle the durations come straight from the preset inputs.
    assign src_preset_s = (state_r == PH_IDLE) ? in_preset_s : preset_r;

    assign run_s    = (state_r == PH_FILL) || (state_r == PH_WASH) ||
                      (state_r == PH_RINSE) || (state_r == PH_SPIN);
    assign frozen_s = run_s && (pause || door_open);
    // Prescaler only runs in a live run phase or the abort drain.
    assign hold_s   = frozen_s || !(run_s || (state_r == PH_ABORT));

    wm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (entering_s),
        .hold  (hold_s),
        .tick  (tick_s)
    );

    // Next-state and remaining-count step; abort outranks freeze and tick.
    always_comb begin
        next_state_s = state_r;
        rem_step_s   = remaining_r;
        latch_s      = 1'b0;
        case (state_r)
            PH_IDLE: begin
                if (start && !door_open && !abort) begin
                    latch_s      = 1'b1;
                    next_state_s = next_run_phase(PH_IDLE, in_preset_s);
                end else begin
                    next_state_s = PH_IDLE;
                end
            end
            PH_FILL, PH_WASH, PH_RINSE, PH_SPIN: begin
                if (abort) begin
                    next_state_s = PH_ABORT;
                end else if (tick_s) begin
                    if (remaining_r == 5'd1) begin
                        next_state_s = next_run_phase(state_r, preset_r);
                    end else begin
                        rem_step_s = remaining_r - 5'd1;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            PH_ABORT: begin
                if (tick_s) begin
                    if (remaining_r == 5'd1) begin
                        next_state_s = PH_IDLE;
                    end else begin
                        rem_step_s = remaining_r - 5'd1;
                    end
                end else begin
                    next_state_s = PH_ABORT;
                end
            end
            PH_DONE: begin
                next_state_s = PH_IDLE;
            end
            default: begin
                next_state_s = PH_IDLE;
            end
        endcase
    end

    // Load value for the phase being entered.
    always_comb begin
        rem_entry_s = 5'd0;
        case (next_state_s)
            PH_FILL, PH_WASH, PH_RINSE, PH_SPIN: rem_entry_s = phase_duration(next_state_s, src_preset_s);
            PH_ABORT:                            rem_entry_s = DRAIN_LOAD;
            default:                             rem_entry_s = 5'd0;
        endcase
    end

    assign entering_s = (next_state_s != state_r);
    assign rem_next_s = entering_s ? rem_entry_s : rem_step_s;

    assign next_run_s    = (next_state_s == PH_FILL) || (next_state_s == PH_WASH) ||
                           (next_state_s == PH_RINSE) || (next_state_s == PH_SPIN);
    assign next_frozen_s = next_run_s && (pause || door_open);

    // Actuator decode for the coming cycle; freeze gates valve/motor/spin but not drain.
    always_comb begin
        valve_s   = 1'b0;
        motor_s   = 1'b0;
        drain_s   = 1'b0;
        spin_hi_s = 1'b0;
        case (next_state_s)
            PH_FILL:  valve_s = !next_frozen_s;
            PH_WASH:  motor_s = !next_frozen_s;
            PH_RINSE: begin
                valve_s = !next_frozen_s;
                motor_s = !next_frozen_s;
            end
            PH_SPIN: begin
                motor_s   = !next_frozen_s;
                spin_hi_s = !next_frozen_s;
                drain_s   = 1'b1;
            end
            PH_ABORT: drain_s = 1'b1;
            default:  drain_s = 1'b0;
        endcase
    end

    // State, counter, latched presets and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= PH_IDLE;
            remaining_r <= 5'd0;
            preset_r    <= '0;
            valve_r     <= 1'b0;
            motor_r     <= 1'b0;
            drain_r     <= 1'b0;
            spin_hi_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            remaining_r <= rem_next_s;
            preset_r    <= latch_s ? in_preset_s : preset_r;
            valve_r     <= valve_s;
            motor_r     <= motor_s;
            drain_r     <= drain_s;
            spin_hi_r   <= spin_hi_s;
            busy_r      <= (next_state_s != PH_IDLE);
            done_r      <= (next_state_s == PH_DONE);
        end
    end

    assign phase     = state_r;
    assign remaining = remaining_r;
    assign valve     = valve_r;
    assign motor     = motor_r;
    assign drain     = drain_r;
    assign spin_hi   = spin_hi_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_wm_cycle_controller.sv
// Scoreboard bench for wm_cycle_controller with TICK_DIV=2, DRAIN_UNITS=3.
// Stimulus pushes hand-derived per-cycle output expectations; a monitor on the
// falling edge pops and compares the entry scheduled for the current cycle.
module tb_wm_cycle_controller;

    localparam int TD = 2;

    localparam logic [2:0] IDLE = 3'd0, FILL = 3'd1, WASH = 3'd2, RINSE = 3'd3,
                           SPIN = 3'd4, DONE = 3'd5, ABRT = 3'd6;

    // flags = {valve, motor, drain, spin_hi, busy, done}
    localparam logic [5:0] F_IDLE  = 6'b000000;
    localparam logic [5:0] F_FILL  = 6'b100010;
    localparam logic [5:0] F_WASH  = 6'b010010;
    localparam logic [5:0] F_RINSE = 6'b110010;
    localparam logic [5:0] F_SPIN  = 6'b011110;
    localparam logic [5:0] F_DONE  = 6'b000011;
    localparam logic [5:0] F_ABRT  = 6'b001010;
    localparam logic [5:0] F_PAUSE = 6'b000010;

    logic clk = 1'b0;
    logic rst, start, pause, door_open, abort;
    logic [4:0] wash_out, rinse_out, spin_out, cloth_out;
    logic [2:0] phase;
    logic [4:0] remaining;
    logic valve, motor, drain, spin_hi, busy, done;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [2:0] ph;
        logic [4:0] rem;
        logic [5:0] fl;
    } exp_t;
    exp_t q[$];

    wm_cycle_controller #(.TICK_DIV(TD), .DRAIN_UNITS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .door_open(door_open),
        .abort(abort), .wash_out(wash_out), .rinse_out(rinse_out), .spin_out(spin_out),
        .cloth_out(cloth_out), .phase(phase), .remaining(remaining), .valve(valve),
        .motor(motor), .drain(drain), .spin_hi(spin_hi), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] flags_of(input logic [2:0] ph);
        case (ph)
            FILL:    return F_FILL;
            WASH:    return F_WASH;
            RINSE:   return F_RINSE;
            SPIN:    return F_SPIN;
            DONE:    return F_DONE;
            ABRT:    return F_ABRT;
            default: return F_IDLE;
        endcase
    endfunction

    task automatic push_exp(input int c, input logic [2:0] ph, input logic [4:0] rem, input logic [5:0] fl);
        exp_t e;
        e.cyc = c; e.ph = ph; e.rem = rem; e.fl = fl;
        q.push_back(e);
    endtask

    // Unfrozen phase of 'units' time units starting at cycle c0.
    task automatic seg(input int c0, input logic [2:0] ph, input int units);
        for (int k = 0; k < units * TD; k++)
            push_exp(c0 + k, ph, 5'(units - k / TD), flags_of(ph));
    endtask

    task automatic idle_span(input int c0, input int n);
        for (int k = 0; k < n; k++) push_exp(c0 + k, IDLE, 5'd0, F_IDLE);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_preset(input logic [4:0] c, input logic [4:0] w, input logic [4:0] r, input logic [4:0] s);
        cloth_out = c; wash_out = w; rinse_out = r; spin_out = s;
    endtask

    // Monitor: compare the expectation scheduled for this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_check cyc=%0d got nothing expected ph=%0d", q[0].cyc, q[0].ph);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            checks++;
            if (phase !== q[0].ph || remaining !== q[0].rem ||
                {valve, motor, drain, spin_hi, busy, done} !== q[0].fl) begin
                errors++;
                $display("FAIL outputs cyc=%0d got ph=%0d rem=%0d vmdsbd=%b expected ph=%0d rem=%0d vmdsbd=%b",
                         cyc, phase, remaining, {valve, motor, drain, spin_hi, busy, done},
                         q[0].ph, q[0].rem, q[0].fl);
            end
            void'(q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, t2;
        rst = 1'b1; start = 1'b0; pause = 1'b0; door_open = 1'b0; abort = 1'b0;
        set_preset(5'd0, 5'd0, 5'd0, 5'd0);
        idle_span(3, 2);
        goto(3);
        rst = 1'b0;

        // Full cycle; presets scrambled after acceptance must not matter.
        t = 6;
        goto(t);
        seg(t + 1, FILL, 2); seg(t + 5, WASH, 3); seg(t + 11, RINSE, 1); seg(t + 13, SPIN, 2);
        push_exp(t + 17, DONE, 5'd0, F_DONE);
        idle_span(t + 18, 2);
        set_preset(5'd2, 5'd3, 5'd1, 5'd2); start = 1'b1;
        goto(t + 1);
        start = 1'b0; set_preset(5'd31, 5'd31, 5'd31, 5'd31);
        goto(t + 21);

        // Zero-length WASH and RINSE are skipped.
        t = 32;
        goto(t);
        seg(t + 1, FILL, 1); seg(t + 3, SPIN, 1);
        push_exp(t + 5, DONE, 5'd0, F_DONE);
        idle_span(t + 6, 2);
        set_preset(5'd1, 5'd0, 5'd0, 5'd1); start = 1'b1;
        goto(t + 1);
        start = 1'b0;
        goto(t + 9);

        // All presets zero: straight to DONE.
        t = 44;
        goto(t);
        push_exp(t + 1, DONE, 5'd0, F_DONE);
        idle_span(t + 2, 3);
        set_preset(5'd0, 5'd0, 5'd0, 5'd0); start = 1'b1;
        goto(t + 1);
        start = 1'b0;
        goto(t + 6);

        // Pause for 5 cycles while WASH shows remaining=2.
        t = 54;
        goto(t);
        seg(t + 1, FILL, 2);
        for (int c = t + 5; c <= t + 15; c++)
            push_exp(c, WASH, (c < t + 7) ? 5'd3 : ((c < t + 14) ? 5'd2 : 5'd1),
                     (c >= t + 8 && c <= t + 12) ? F_PAUSE : F_WASH);
        seg(t + 16, RINSE, 1); seg(t + 18, SPIN, 2);
        push_exp(t + 22, DONE, 5'd0, F_DONE);
        idle_span(t + 23, 2);
        set_preset(5'd2, 5'd3, 5'd1, 5'd2); start = 1'b1;
        goto(t + 1);
        start = 1'b0;
        goto(t + 7);
        pause = 1'b1;
        goto(t + 12);
        pause = 1'b0;
        goto(t + 26);

        // Abort in RINSE, door opened during the drain.
        t = 84;
        goto(t);
        seg(t + 1, FILL, 2); seg(t + 5, WASH, 3);
        push_exp(t + 11, RINSE, 5'd1, F_RINSE);
        seg(t + 12, ABRT, 3);
        idle_span(t + 18, 4);
        set_preset(5'd2, 5'd3, 5'd1, 5'd2); start = 1'b1;
        goto(t + 1);
        start = 1'b0;
        goto(t + 11);
        abort = 1'b1;
        goto(t + 12);
        abort = 1'b0; door_open = 1'b1;
        goto(t + 18);
        door_open = 1'b0;
        goto(t + 23);

        // Start blocked by door_open, then start together with abort.
        t = 110;
        goto(t);
        idle_span(t + 1, 4);
        set_preset(5'd2, 5'd3, 5'd1, 5'd2); door_open = 1'b1; start = 1'b1;
        goto(t + 2);
        door_open = 1'b0; abort = 1'b1;
        goto(t + 3);
        start = 1'b0; abort = 1'b0;

        // Reset during SPIN.
        t2 = t + 6;
        goto(t2);
        seg(t2 + 1, FILL, 2); seg(t2 + 5, WASH, 3); seg(t2 + 11, RINSE, 1);
        push_exp(t2 + 13, SPIN, 5'd2, F_SPIN);
        push_exp(t2 + 14, SPIN, 5'd2, F_SPIN);
        idle_span(t2 + 15, 4);
        start = 1'b1;
        goto(t2 + 1);
        start = 1'b0;
        goto(t2 + 14);
        rst = 1'b1;
        goto(t2 + 15);
        rst = 1'b0;
        goto(t2 + 21);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
